// File: rtl/conv3x3_stream_filter.sv
`timescale 1ns/1ps
// Streaming 3x3 convolution on RGB444 pixels, per channel, kernel (pass/gauss/sharpen/laplace) latched per frame.
// Latency: an output is produced IMG_W+1 accepted pixels after its centre; an end-of-frame flush drains the last IMG_W+1.
// Backpressure: single output register; input is stalled in RUN and flush steps pause while the output slot is occupied.
module conv3x3_stream_filter #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int PIX_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_mode,
    input  logic [PIX_W-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_in_sop,
    input  logic             i_in_eop,
    output logic [PIX_W-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_sop,
    output logic             o_out_eop,
    output logic             o_frame_err
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [COL_W-1:0] r_in_col;
    logic [ROW_W-1:0] r_in_row;
    logic [COL_W-1:0] r_out_col;
    logic [ROW_W-1:0] r_out_row;
    logic [COL_W-1:0] r_lb_ptr;
    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb2 [IMG_W];
    logic [PIX_W-1:0] r_win [3][3];

    logic             w_slot_free;
    logic             w_accept;
    logic             w_start;
    logic             w_take;
    logic             w_flush_step;
    logic             w_shift;
    logic             w_produce;
    logic [COL_W-1:0] w_pos_col;
    logic [ROW_W-1:0] w_pos_row;
    logic             w_pos_last;
    logic [COL_W-1:0] w_nxt_col;
    logic [ROW_W-1:0] w_nxt_row;
    logic [COL_W-1:0] w_ptr;
    logic [PIX_W-1:0] w_shift_in;
    logic [PIX_W-1:0] w_nw [3][3];
    logic             w_border;
    logic             w_out_last;
    logic [PIX_W-1:0] w_pix_out;

    // One 4-bit channel of the selected kernel; c is centre, n/s/e/w edges, nw/ne/sw/se diagonals
    function automatic logic [3:0] filt_ch(
        input logic [1:0] mode,
        input logic [3:0] c, n, s, e, w, nw, ne, sw, se
    );
        logic [9:0]        edg;
        logic [9:0]        dia;
        logic [9:0]        cc;
        logic [9:0]        g;
        logic signed [9:0] acc;
        logic [3:0]        res;
        edg = 10'(n) + 10'(s) + 10'(e) + 10'(w);
        dia = 10'(nw) + 10'(ne) + 10'(sw) + 10'(se);
        cc  = 10'(c);
        res = c;
        case (mode)
            2'd1: begin
                g   = (cc << 2) + (edg << 1) + dia;
                res = 4'(g >> 4);
            end
            2'd2: begin
                acc = $signed(cc * 10'd5) - $signed(edg);
                if (acc < 0)        res = 4'd0;
                else if (acc > 15)  res = 4'd15;
                else                res = 4'(acc);
            end
            2'd3: begin
                acc = $signed(cc << 3) - $signed(edg + dia);
                if (acc < 0) acc = -acc;
                res = (acc > 15) ? 4'd15 : 4'(acc);
            end
            default: res = c;
        endcase
        return res;
    endfunction

    assign w_slot_free = !o_out_valid || i_out_ready;

    // Input acceptance depends on the phase of the frame and, while streaming, on the output slot
    always_comb begin
        o_in_ready = 1'b1;
        case (r_state)
            S_RUN:   o_in_ready = w_slot_free;
            S_FLUSH: o_in_ready = 1'b0;
            default: o_in_ready = 1'b1;
        endcase
    end

    assign w_accept     = i_in_valid && o_in_ready;
    assign w_start      = w_accept && i_in_sop;
    assign w_take       = w_accept && (w_start || r_state == S_FILL || r_state == S_RUN);
    assign w_flush_step = (r_state == S_FLUSH) && w_slot_free;
    assign w_shift      = w_take || w_flush_step;
    assign w_produce    = (r_state == S_RUN && w_accept && !i_in_sop) || w_flush_step;
    assign w_pos_col    = w_start ? '0 : r_in_col;
    assign w_pos_row    = w_start ? '0 : r_in_row;
    assign w_pos_last   = (w_pos_row == LAST_ROW) && (w_pos_col == LAST_COL);
    assign w_ptr        = w_start ? '0 : r_lb_ptr;
    assign w_shift_in   = (r_state == S_FLUSH) ? '0 : i_in_data;
    assign w_out_last   = (r_out_row == LAST_ROW) && (r_out_col == LAST_COL);

    // Raster position of the pixel following the one being accepted
    always_comb begin
        w_nxt_col = w_pos_col + COL_W'(1);
        w_nxt_row = w_pos_row;
        if (w_pos_col == LAST_COL) begin
            w_nxt_col = '0;
            w_nxt_row = (w_pos_row == LAST_ROW) ? '0 : w_pos_row + ROW_W'(1);
        end
    end

    // Window as it will look after this shift: columns move left, right column fed by line buffers and input
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_nw[r][0] = r_win[r][1];
            w_nw[r][1] = r_win[r][2];
        end
        w_nw[0][2] = r_lb2[w_ptr];
        w_nw[1][2] = r_lb1[w_ptr];
        w_nw[2][2] = w_shift_in;
    end

    // Border centres pass through untouched; interior centres go through the latched kernel
    always_comb begin
        w_border  = (r_out_row == '0) || (r_out_row == LAST_ROW) ||
                    (r_out_col == '0) || (r_out_col == LAST_COL);
        w_pix_out = w_nw[1][1];
        if (!w_border) begin
            for (int ch = 0; ch < 3; ch++) begin
                w_pix_out[ch*4 +: 4] = filt_ch(r_mode,
                    w_nw[1][1][ch*4 +: 4],
                    w_nw[0][1][ch*4 +: 4], w_nw[2][1][ch*4 +: 4],
                    w_nw[1][2][ch*4 +: 4], w_nw[1][0][ch*4 +: 4],
                    w_nw[0][0][ch*4 +: 4], w_nw[0][2][ch*4 +: 4],
                    w_nw[2][0][ch*4 +: 4], w_nw[2][2][ch*4 +: 4]);
            end
        end
    end

    // Pixel storage: line buffers hold the two previous rows, window holds the 3x3 neighbourhood
    always_ff @(posedge i_clk) begin
        if (w_shift) begin
            r_win        <= w_nw;
            r_lb1[w_ptr] <= w_shift_in;
            r_lb2[w_ptr] <= r_lb1[w_ptr];
        end
    end

    // Frame FSM, position counters, framing checks and the output register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_in_col    <= '0;
            r_in_row    <= '0;
            r_out_col   <= '0;
            r_out_row   <= '0;
            r_lb_ptr    <= '0;
            o_out_data  <= '0;
            o_out_valid <= 1'b0;
            o_out_sop   <= 1'b0;
            o_out_eop   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= w_take && ((w_start && r_state != S_IDLE) || (i_in_eop != w_pos_last));

            if (w_produce) begin
                o_out_data  <= w_pix_out;
                o_out_valid <= 1'b1;
                o_out_sop   <= (r_out_row == '0) && (r_out_col == '0);
                o_out_eop   <= w_out_last;
            end else if (i_out_ready) begin
                o_out_valid <= 1'b0;
                o_out_sop   <= 1'b0;
                o_out_eop   <= 1'b0;
            end

            if (w_take) begin
                r_in_col <= w_nxt_col;
                r_in_row <= w_nxt_row;
            end

            if (w_shift) begin
                r_lb_ptr <= (w_ptr == LAST_COL) ? '0 : w_ptr + COL_W'(1);
            end

            if (w_start) begin
                r_out_col <= '0;
                r_out_row <= '0;
            end else if (w_produce) begin
                r_out_col <= (r_out_col == LAST_COL) ? '0 : r_out_col + COL_W'(1);
                if (r_out_col == LAST_COL) begin
                    r_out_row <= (r_out_row == LAST_ROW) ? '0 : r_out_row + ROW_W'(1);
                end
            end

            if (w_start) begin
                // A start of frame always wins: abandons any frame in progress
                r_mode  <= i_mode;
                r_state <= S_FILL;
            end else begin
                case (r_state)
                    S_FILL: begin
                        if (w_accept && w_pos_row == ROW_W'(1) && w_pos_col == '0) r_state <= S_RUN;
                    end
                    S_RUN: begin
                        if (w_accept && w_pos_last) r_state <= S_FLUSH;
                    end
                    S_FLUSH: begin
                        if (w_flush_step && w_out_last) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
